// File: rtl/cpu_ctl_pkg.sv
// Shared opcodes, sequencer state encodings and control-vector bit indices
// for the hardwired control unit and the datapath that it drives.
package cpu_ctl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Each instruction class gets its own execute states so the next state
  // never depends on anything but the present state (and ir in F2).
  typedef enum logic [4:0] {
    S_RST, S_F0, S_F1, S_F2,
    S_LD_E3, S_LD_E4, S_LD_E5, S_LD_E6, S_LD_E7,
    S_LDI_E3, S_LDI_E4, S_LDI_E5,
    S_ST_E3, S_ST_E4, S_ST_E5, S_ST_E6, S_ST_E7,
    S_ALU_E3, S_ALU_E4, S_ALU_E5,
    S_ALUI_E3, S_ALUI_E4, S_ALUI_E5,
    S_BR_E3, S_BR_E4, S_BR_E5, S_BR_E6,
    S_IN_E3, S_OUT_E3, S_HALT
  } state_t;

  localparam int CLS_W = 4;
  typedef enum logic [CLS_W-1:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU, CL_ALUI, CL_BR, CL_IN, CL_OUT, CL_NOP, CL_HALT
  } iclass_t;

  localparam int LE_W = 10;
  localparam int DE_W = 8;
  localparam int GC_W = 5;
  localparam int AO_W = 13;

  localparam int LE_CONIN = 9, LE_PCIN = 8, LE_IRIN = 7, LE_RYIN = 6, LE_RZIN = 5;
  localparam int LE_MARIN = 4, LE_HILOIN = 3, LE_OUTPUTIN = 2, LE_INTERIN = 1, LE_MDRIN = 0;

  localparam int DE_INPUTOUT = 7, DE_MDROUT = 6, DE_HILOOUT = 5, DE_RZOUT = 4;
  localparam int DE_PCOUT = 3, DE_COUT = 2, DE_INTEROUT = 1, DE_BAOUT = 0;

  localparam int GC_GRA = 4, GC_GRB = 3, GC_GRC = 2, GC_ROUT = 1, GC_RIN = 0;

  localparam int AO_ADD = 12, AO_SUB = 11, AO_MUL = 10, AO_DIV = 9, AO_SHR = 8;
  localparam int AO_SHL = 7, AO_ROR = 6, AO_ROL = 5, AO_AND = 4, AO_OR = 3;
  localparam int AO_NEGATE = 2, AO_NOT = 1, AO_INCPC = 0;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: instruction class, one-hot ALU op and an
// illegal-opcode flag.
module opcode_decoder
  import cpu_ctl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output logic [CLS_W-1:0] cls,
  output logic [AO_W-1:0]  alu,
  output logic             illegal
);

  logic [4:0] op;
  assign op = 5'(opc);

  always_comb begin
    cls     = CL_HALT;
    alu     = '0;
    illegal = 1'b0;
    case (op)
      OP_LD:   cls = CL_LD;
      OP_LDI:  cls = CL_LDI;
      OP_ST:   cls = CL_ST;
      OP_ADD:  begin cls = CL_ALU;  alu[AO_ADD] = 1'b1; end
      OP_SUB:  begin cls = CL_ALU;  alu[AO_SUB] = 1'b1; end
      OP_SHR:  begin cls = CL_ALU;  alu[AO_SHR] = 1'b1; end
      OP_SHL:  begin cls = CL_ALU;  alu[AO_SHL] = 1'b1; end
      OP_ROR:  begin cls = CL_ALU;  alu[AO_ROR] = 1'b1; end
      OP_ROL:  begin cls = CL_ALU;  alu[AO_ROL] = 1'b1; end
      OP_AND:  begin cls = CL_ALU;  alu[AO_AND] = 1'b1; end
      OP_OR:   begin cls = CL_ALU;  alu[AO_OR]  = 1'b1; end
      OP_ADDI: begin cls = CL_ALUI; alu[AO_ADD] = 1'b1; end
      OP_ANDI: begin cls = CL_ALUI; alu[AO_AND] = 1'b1; end
      OP_ORI:  begin cls = CL_ALUI; alu[AO_OR]  = 1'b1; end
      OP_BR:   cls = CL_BR;
      OP_IN:   cls = CL_IN;
      OP_OUT:  cls = CL_OUT;
      OP_NOP:  cls = CL_NOP;
      OP_HALT: cls = CL_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, decode and per-class micro-op sequencing.
// Control outputs are a combinational decode of the present state.
module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int OPC_W = 5,
  parameter int ST_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] ir,
  input  logic            con,
  output logic [9:0]      load_en,
  output logic [7:0]      drive_en,
  output logic [4:0]      gpr_ctl,
  output logic [12:0]     alu_op,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            run,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  state_t           st;
  logic [CLS_W-1:0] cls_bits;
  logic [AO_W-1:0]  dec_alu;
  logic             dec_illegal;
  logic             unused_ir;

  assign unused_ir = ^ir[BITS-OPC_W-1:0];
  assign state     = ST_W'(st);

  opcode_decoder #(.OPC_W(OPC_W)) u_dec (
    .opc     (ir[BITS-1 -: OPC_W]),
    .cls     (cls_bits),
    .alu     (dec_alu),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_RST;
      illegal <= 1'b0;
    end else begin
      case (st)
        S_RST: st <= S_F0;
        S_F0:  st <= S_F1;
        S_F1:  st <= S_F2;
        S_F2: begin
          if (dec_illegal) illegal <= 1'b1;
          case (iclass_t'(cls_bits))
            CL_LD:   st <= S_LD_E3;
            CL_LDI:  st <= S_LDI_E3;
            CL_ST:   st <= S_ST_E3;
            CL_ALU:  st <= S_ALU_E3;
            CL_ALUI: st <= S_ALUI_E3;
            CL_BR:   st <= S_BR_E3;
            CL_IN:   st <= S_IN_E3;
            CL_OUT:  st <= S_OUT_E3;
            CL_NOP:  st <= S_F0;
            default: st <= S_HALT;
          endcase
        end
        S_LD_E3:   st <= S_LD_E4;
        S_LD_E4:   st <= S_LD_E5;
        S_LD_E5:   st <= S_LD_E6;
        S_LD_E6:   st <= S_LD_E7;
        S_LDI_E3:  st <= S_LDI_E4;
        S_LDI_E4:  st <= S_LDI_E5;
        S_ST_E3:   st <= S_ST_E4;
        S_ST_E4:   st <= S_ST_E5;
        S_ST_E5:   st <= S_ST_E6;
        S_ST_E6:   st <= S_ST_E7;
        S_ALU_E3:  st <= S_ALU_E4;
        S_ALU_E4:  st <= S_ALU_E5;
        S_ALUI_E3: st <= S_ALUI_E4;
        S_ALUI_E4: st <= S_ALUI_E5;
        S_BR_E3:   st <= S_BR_E4;
        S_BR_E4:   st <= S_BR_E5;
        S_BR_E5:   st <= S_BR_E6;
        S_LD_E7, S_LDI_E5, S_ST_E7, S_ALU_E5, S_ALUI_E5,
        S_BR_E6, S_IN_E3, S_OUT_E3: st <= S_F0;
        default:   st <= S_HALT;
      endcase
    end
  end

  always_comb begin
    load_en  = '0;
    drive_en = '0;
    gpr_ctl  = '0;
    alu_op   = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    run      = 1'b1;
    case (st)
      S_F0: begin
        drive_en[DE_PCOUT] = 1'b1; load_en[LE_MARIN] = 1'b1;
        alu_op[AO_INCPC]   = 1'b1; load_en[LE_RZIN]  = 1'b1;
      end
      S_F1: begin
        drive_en[DE_RZOUT] = 1'b1; load_en[LE_PCIN] = 1'b1;
        mem_rd             = 1'b1; load_en[LE_MDRIN] = 1'b1;
      end
      S_F2: begin drive_en[DE_MDROUT] = 1'b1; load_en[LE_IRIN] = 1'b1; end
      // Base + displacement address/value computation shared by ld, ldi, st
      S_LD_E3, S_LDI_E3, S_ST_E3: begin
        gpr_ctl[GC_GRB] = 1'b1; drive_en[DE_BAOUT] = 1'b1; load_en[LE_RYIN] = 1'b1;
      end
      S_LD_E4, S_LDI_E4, S_ST_E4, S_BR_E5: begin
        drive_en[DE_COUT] = 1'b1; alu_op[AO_ADD] = 1'b1; load_en[LE_RZIN] = 1'b1;
      end
      S_LD_E5, S_ST_E5: begin drive_en[DE_RZOUT] = 1'b1; load_en[LE_MARIN] = 1'b1; end
      S_LD_E6: begin mem_rd = 1'b1; load_en[LE_MDRIN] = 1'b1; end
      S_LD_E7: begin
        drive_en[DE_MDROUT] = 1'b1; gpr_ctl[GC_GRA] = 1'b1; gpr_ctl[GC_RIN] = 1'b1;
      end
      S_LDI_E5, S_ALU_E5, S_ALUI_E5: begin
        drive_en[DE_RZOUT] = 1'b1; gpr_ctl[GC_GRA] = 1'b1; gpr_ctl[GC_RIN] = 1'b1;
      end
      S_ST_E6: begin
        gpr_ctl[GC_GRA] = 1'b1; gpr_ctl[GC_ROUT] = 1'b1; load_en[LE_MDRIN] = 1'b1;
      end
      S_ST_E7: mem_wr = 1'b1;
      S_ALU_E3, S_ALUI_E3: begin
        gpr_ctl[GC_GRB] = 1'b1; gpr_ctl[GC_ROUT] = 1'b1; load_en[LE_RYIN] = 1'b1;
      end
      S_ALU_E4: begin
        gpr_ctl[GC_GRC] = 1'b1; gpr_ctl[GC_ROUT] = 1'b1; load_en[LE_RZIN] = 1'b1;
        alu_op = dec_alu;
      end
      S_ALUI_E4: begin
        drive_en[DE_COUT] = 1'b1; load_en[LE_RZIN] = 1'b1; alu_op = dec_alu;
      end
      S_BR_E3: begin
        gpr_ctl[GC_GRA] = 1'b1; gpr_ctl[GC_ROUT] = 1'b1; load_en[LE_CONIN] = 1'b1;
      end
      S_BR_E4: begin drive_en[DE_PCOUT] = 1'b1; load_en[LE_RYIN] = 1'b1; end
      // Not-taken branch still spends this clock, with every strobe idle
      S_BR_E6: begin drive_en[DE_RZOUT] = con; load_en[LE_PCIN] = con; end
      S_IN_E3: begin
        drive_en[DE_INPUTOUT] = 1'b1; gpr_ctl[GC_GRA] = 1'b1; gpr_ctl[GC_RIN] = 1'b1;
      end
      S_OUT_E3: begin
        gpr_ctl[GC_GRA] = 1'b1; gpr_ctl[GC_ROUT] = 1'b1; load_en[LE_OUTPUTIN] = 1'b1;
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class cycle by
// cycle against hand-built control vectors.
module tb_control_sequencer;
  import cpu_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir;
  logic        con;
  logic [9:0]  load_en;
  logic [7:0]  drive_en;
  logic [4:0]  gpr_ctl;
  logic [12:0] alu_op;
  logic        mem_rd, mem_wr, run, illegal;
  logic [4:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  control_sequencer #(.BITS(32), .OPC_W(5), .ST_W(5)) dut (
    .clk(clk), .reset(reset), .ir(ir), .con(con),
    .load_en(load_en), .drive_en(drive_en), .gpr_ctl(gpr_ctl), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .run(run), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Packed as {load_en, drive_en, gpr_ctl, alu_op, mem_rd, mem_wr, run, illegal}
  function automatic logic [39:0] v(logic [9:0] le, logic [7:0] de, logic [4:0] gc,
                                    logic [12:0] ao, logic rd, logic wr, logic rn, logic il);
    return {le, de, gc, ao, rd, wr, rn, il};
  endfunction

  logic [39:0] obs;
  assign obs = {load_en, drive_en, gpr_ctl, alu_op, mem_rd, mem_wr, run, illegal};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [4:0] exp_st, logic [39:0] exp_v);
    n_assert++;
    assert (state === exp_st) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_st);
    end
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(string tag, logic [4:0] exp_st, logic [39:0] exp_v);
    chk(tag, exp_st, exp_v);
    step();
  endtask

  logic [39:0] V_IDLE, V_F0, V_F1, V_F2, V_LD3, V_LD4, V_LD5, V_LD6, V_LD7, V_WB;
  logic [39:0] V_ST6, V_ST7, V_ALU3, V_SUB4, V_ORI4, V_BR3, V_BR4, V_BR6T;
  logic [39:0] V_IN3, V_OUT3, V_HALT, V_ILL;

  task automatic fetch(string tag);
    cyc({tag, "_f0"}, S_F0, V_F0);
    cyc({tag, "_f1"}, S_F1, V_F1);
    cyc({tag, "_f2"}, S_F2, V_F2);
  endtask

  initial begin
    V_IDLE = v(10'h000, 8'h00, 5'h00, 13'h0000, 0, 0, 1, 0);
    V_F0   = v(10'h030, 8'h08, 5'h00, 13'h0001, 0, 0, 1, 0);
    V_F1   = v(10'h101, 8'h10, 5'h00, 13'h0000, 1, 0, 1, 0);
    V_F2   = v(10'h080, 8'h40, 5'h00, 13'h0000, 0, 0, 1, 0);
    V_LD3  = v(10'h040, 8'h01, 5'h08, 13'h0000, 0, 0, 1, 0);
    V_LD4  = v(10'h020, 8'h04, 5'h00, 13'h1000, 0, 0, 1, 0);
    V_LD5  = v(10'h010, 8'h10, 5'h00, 13'h0000, 0, 0, 1, 0);
    V_LD6  = v(10'h001, 8'h00, 5'h00, 13'h0000, 1, 0, 1, 0);
    V_LD7  = v(10'h000, 8'h40, 5'h11, 13'h0000, 0, 0, 1, 0);
    V_WB   = v(10'h000, 8'h10, 5'h11, 13'h0000, 0, 0, 1, 0);
    V_ST6  = v(10'h001, 8'h00, 5'h12, 13'h0000, 0, 0, 1, 0);
    V_ST7  = v(10'h000, 8'h00, 5'h00, 13'h0000, 0, 1, 1, 0);
    V_ALU3 = v(10'h040, 8'h00, 5'h0A, 13'h0000, 0, 0, 1, 0);
    V_SUB4 = v(10'h020, 8'h00, 5'h06, 13'h0800, 0, 0, 1, 0);
    V_ORI4 = v(10'h020, 8'h04, 5'h00, 13'h0008, 0, 0, 1, 0);
    V_BR3  = v(10'h200, 8'h00, 5'h12, 13'h0000, 0, 0, 1, 0);
    V_BR4  = v(10'h040, 8'h08, 5'h00, 13'h0000, 0, 0, 1, 0);
    V_BR6T = v(10'h100, 8'h10, 5'h00, 13'h0000, 0, 0, 1, 0);
    V_IN3  = v(10'h000, 8'h80, 5'h11, 13'h0000, 0, 0, 1, 0);
    V_OUT3 = v(10'h004, 8'h00, 5'h12, 13'h0000, 0, 0, 1, 0);
    V_HALT = v(10'h000, 8'h00, 5'h00, 13'h0000, 0, 0, 0, 0);
    V_ILL  = v(10'h000, 8'h00, 5'h00, 13'h0000, 0, 0, 0, 1);

    reset = 1'b1; ir = 32'h0; con = 1'b0;
    step(); step();
    chk("reset", S_RST, V_IDLE);
    reset = 1'b0;
    step();

    // ld r1,0x55(r0)
    ir = 32'h00800055;
    fetch("ld");
    cyc("ld_e3", S_LD_E3, V_LD3);
    cyc("ld_e4", S_LD_E4, V_LD4);
    cyc("ld_e5", S_LD_E5, V_LD5);
    cyc("ld_e6", S_LD_E6, V_LD6);
    cyc("ld_e7", S_LD_E7, V_LD7);

    ir = 32'h08800007;
    fetch("ldi");
    cyc("ldi_e3", S_LDI_E3, V_LD3);
    cyc("ldi_e4", S_LDI_E4, V_LD4);
    cyc("ldi_e5", S_LDI_E5, V_WB);

    ir = 32'h10800020;
    fetch("st");
    cyc("st_e3", S_ST_E3, V_LD3);
    cyc("st_e4", S_ST_E4, V_LD4);
    cyc("st_e5", S_ST_E5, V_LD5);
    cyc("st_e6", S_ST_E6, V_ST6);
    cyc("st_e7", S_ST_E7, V_ST7);

    ir = 32'h20000000;
    fetch("sub");
    cyc("sub_e3", S_ALU_E3, V_ALU3);
    cyc("sub_e4", S_ALU_E4, V_SUB4);
    cyc("sub_e5", S_ALU_E5, V_WB);

    ir = 32'h68000000;
    fetch("ori");
    cyc("ori_e3", S_ALUI_E3, V_ALU3);
    cyc("ori_e4", S_ALUI_E4, V_ORI4);
    cyc("ori_e5", S_ALUI_E5, V_WB);

    ir = 32'h91800005; con = 1'b1;
    fetch("brt");
    cyc("brt_e3", S_BR_E3, V_BR3);
    cyc("brt_e4", S_BR_E4, V_BR4);
    cyc("brt_e5", S_BR_E5, V_LD4);
    cyc("brt_e6", S_BR_E6, V_BR6T);

    con = 1'b0;
    fetch("brn");
    cyc("brn_e3", S_BR_E3, V_BR3);
    cyc("brn_e4", S_BR_E4, V_BR4);
    cyc("brn_e5", S_BR_E5, V_LD4);
    cyc("brn_e6", S_BR_E6, V_IDLE);

    ir = 32'hB0000000;
    fetch("in");
    cyc("in_e3", S_IN_E3, V_IN3);

    ir = 32'hB8000000;
    fetch("out");
    cyc("out_e3", S_OUT_E3, V_OUT3);

    ir = 32'hD0000000;
    fetch("nop");

    // st aborted by reset in E6: the write state must never be reached
    ir = 32'h10800020;
    fetch("sta");
    cyc("sta_e3", S_ST_E3, V_LD3);
    cyc("sta_e4", S_ST_E4, V_LD4);
    cyc("sta_e5", S_ST_E5, V_LD5);
    chk("sta_e6", S_ST_E6, V_ST6);
    reset = 1'b1;
    step();
    chk("sta_rst", S_RST, V_IDLE);
    reset = 1'b0;
    step();

    ir = 32'hD8000000;
    fetch("halt");
    for (int i = 0; i < 3; i++) cyc("halt_hold", S_HALT, V_HALT);
    reset = 1'b1;
    step();
    chk("halt_rst", S_RST, V_IDLE);
    reset = 1'b0;
    step();

    ir = 32'h70000000;
    fetch("ill");
    for (int i = 0; i < 10; i++) cyc("ill_hold", S_HALT, V_ILL);
    reset = 1'b1;
    step();
    chk("ill_rst", S_RST, V_IDLE);
    reset = 1'b0;
    step();
    chk("ill_f0", S_F0, V_F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
